// File: rtl/ald_cycle_sequencer.sv
// ALD recipe sequencer: pump-down, then n_cycles of precursor pulse / purge /
// water pulse / purge, timed in DownClock ticks, with stop and interlock handling.
module ald_cycle_sequencer #(
  parameter int unsigned TW = 32,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          start,
  input  logic          stop,
  input  logic          interlock_ok,
  input  logic          fault_clr,
  input  logic [TW-1:0] t_pump,
  input  logic [TW-1:0] t_pulse_p,
  input  logic [TW-1:0] t_purge_p,
  input  logic [TW-1:0] t_pulse_w,
  input  logic [TW-1:0] t_purge_w,
  input  logic [CW-1:0] n_cycles,
  output logic          sv_prec,
  output logic          sv_water,
  output logic          vv_vac,
  output logic          busy,
  output logic          done,
  output logic          fault,
  output logic [CW-1:0] cycle_cnt,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PUMP   = 3'd1,
    S_PPULSE = 3'd2,
    S_PPURGE = 3'd3,
    S_WPULSE = 3'd4,
    S_WPURGE = 3'd5,
    S_ABORT  = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] pump_q, pulse_p_q, purge_p_q, pulse_w_q, purge_w_q;
  logic [CW-1:0] ncyc_q;
  logic [CW-1:0] cycle_d, cycle_nxt;
  logic          start_q, start_rise, latch_cfg, done_d, in_run;

  assign start_rise = start & ~start_q;
  assign in_run     = (state_q inside {S_PUMP, S_PPULSE, S_PPURGE, S_WPULSE, S_WPURGE});
  assign cycle_nxt  = cycle_cnt + CW'(1);
  assign state      = state_q;

  // Next-state, phase timer and cycle counter decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cycle_d   = cycle_cnt;
    done_d    = 1'b0;
    latch_cfg = 1'b0;
    if (in_run && stop) begin
      state_d = S_ABORT;
    end else if (in_run && !interlock_ok) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_rise && (n_cycles != '0) && interlock_ok && !stop) begin
            latch_cfg = 1'b1;
            cycle_d   = '0;
            state_d   = S_PUMP;
            cnt_d     = t_pump;
          end
        end
        S_ABORT: begin
          if (!stop) state_d = S_IDLE;
        end
        S_FAULT: begin
          if (fault_clr && interlock_ok) state_d = S_IDLE;
        end
        default: begin
          if (cnt_q == '0) begin
            case (state_q)
              S_PUMP:   begin state_d = S_PPULSE; cnt_d = pulse_p_q; end
              S_PPULSE: begin state_d = S_PPURGE; cnt_d = purge_p_q; end
              S_PPURGE: begin state_d = S_WPULSE; cnt_d = pulse_w_q; end
              S_WPULSE: begin state_d = S_WPURGE; cnt_d = purge_w_q; end
              S_WPURGE: begin
                cycle_d = cycle_nxt;
                if (cycle_nxt == ncyc_q) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                end else begin
                  state_d = S_PPULSE;
                  cnt_d   = pulse_p_q;
                end
              end
              default: ;
            endcase
          end else if (tick) begin
            cnt_d = cnt_q - TW'(1);
          end
        end
      endcase
    end
  end

  // State, timer, latched recipe and Moore outputs decoded from next state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cycle_cnt <= '0;
      start_q   <= 1'b0;
      pump_q    <= '0;
      pulse_p_q <= '0;
      purge_p_q <= '0;
      pulse_w_q <= '0;
      purge_w_q <= '0;
      ncyc_q    <= '0;
      sv_prec   <= 1'b0;
      sv_water  <= 1'b0;
      vv_vac    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cycle_cnt <= cycle_d;
      start_q   <= start;
      if (latch_cfg) begin
        pump_q    <= t_pump;
        pulse_p_q <= t_pulse_p;
        purge_p_q <= t_purge_p;
        pulse_w_q <= t_pulse_w;
        purge_w_q <= t_purge_w;
        ncyc_q    <= n_cycles;
      end
      sv_prec  <= (state_d == S_PPULSE);
      sv_water <= (state_d == S_WPULSE);
      vv_vac   <= (state_d inside {S_PUMP, S_PPURGE, S_WPURGE, S_ABORT});
      busy     <= (state_d inside {S_PUMP, S_PPULSE, S_PPURGE, S_WPULSE, S_WPURGE});
      done     <= done_d;
      fault    <= (state_d == S_FAULT);
    end
  end

endmodule

// File: tb/tb_ald_cycle_sequencer.sv
// Self-checking bench for ald_cycle_sequencer: expected state/valve sequences are
// queued when a run is launched and compared against what the monitor observed.
module tb_ald_cycle_sequencer;

  localparam int unsigned TW = 32;
  localparam int unsigned CW = 16;

  logic          clk, rst, tick, start, stop, interlock_ok, fault_clr;
  logic [TW-1:0] t_pump, t_pulse_p, t_purge_p, t_pulse_w, t_purge_w;
  logic [CW-1:0] n_cycles;
  logic          sv_prec, sv_water, vv_vac, busy, done, fault;
  logic [CW-1:0] cycle_cnt;
  logic [2:0]    state;

  int tests = 0;
  int fails = 0;

  // scoreboard: expected (test side) and observed (monitor side)
  int exp_q[$];
  int exp_prec_q[$];
  int exp_water_q[$];
  int obs_state_q[$];
  int obs_dwell_q[$];
  int prec_tick_q[$];
  int prec_clk_q[$];
  int water_tick_q[$];
  int water_clk_q[$];
  int entries[8];
  int done_clks = 0;
  int valve_clks = 0;
  int dwell = 0;
  int prec_clk = 0;
  int prec_tick = 0;
  int water_clk = 0;
  int water_tick = 0;
  bit overlap = 1'b0;
  int epoch = 0;
  int seen_epoch = 0;
  logic [2:0] prev_state = 3'd0;
  int div = 0;

  ald_cycle_sequencer #(.TW(TW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .interlock_ok(interlock_ok), .fault_clr(fault_clr),
    .t_pump(t_pump), .t_pulse_p(t_pulse_p), .t_purge_p(t_purge_p),
    .t_pulse_w(t_pulse_w), .t_purge_w(t_purge_w), .n_cycles(n_cycles),
    .sv_prec(sv_prec), .sv_water(sv_water), .vv_vac(vv_vac), .busy(busy),
    .done(done), .fault(fault), .cycle_cnt(cycle_cnt), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 1 kHz stand-in: one-clk tick every 4 clocks
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      div  = (div == 3) ? 0 : div + 1;
      tick = (div == 0);
    end
  end

  // Monitor: records state entries, dwell times, valve pulse widths
  initial begin
    foreach (entries[i]) entries[i] = 0;
    forever begin
      @(posedge clk);
      #2;
      if (epoch != seen_epoch) begin
        seen_epoch = epoch;
        obs_state_q.delete();
        obs_dwell_q.delete();
        prec_tick_q.delete();
        prec_clk_q.delete();
        water_tick_q.delete();
        water_clk_q.delete();
        foreach (entries[i]) entries[i] = 0;
        done_clks  = 0;
        valve_clks = 0;
        overlap    = 1'b0;
      end
      if (state != prev_state) begin
        obs_state_q.push_back(int'(state));
        obs_dwell_q.push_back(dwell);
        entries[state] = entries[state] + 1;
        dwell = 1;
      end else begin
        dwell = dwell + 1;
      end
      prev_state = state;
      if (done) done_clks = done_clks + 1;
      if (sv_prec | sv_water | vv_vac) valve_clks = valve_clks + 1;
      if (sv_prec & sv_water) overlap = 1'b1;
      if (sv_prec) begin
        prec_clk = prec_clk + 1;
        if (tick) prec_tick = prec_tick + 1;
      end else if (prec_clk != 0) begin
        prec_tick_q.push_back(prec_tick);
        prec_clk_q.push_back(prec_clk);
        prec_clk  = 0;
        prec_tick = 0;
      end
      if (sv_water) begin
        water_clk = water_clk + 1;
        if (tick) water_tick = water_tick + 1;
      end else if (water_clk != 0) begin
        water_tick_q.push_back(water_tick);
        water_clk_q.push_back(water_clk);
        water_clk  = 0;
        water_tick = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, state=%0d", state);
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    epoch = epoch + 1;
    @(negedge clk);
  endtask

  task automatic set_cfg(input int p, input int pp, input int gp, input int pw,
                         input int gw, input int n);
    t_pump    = TW'(p);
    t_pulse_p = TW'(pp);
    t_purge_p = TW'(gp);
    t_pulse_w = TW'(pw);
    t_purge_w = TW'(gw);
    n_cycles  = CW'(n);
  endtask

  task automatic push_run(input int n);
    exp_q.push_back(1);
    for (int c = 0; c < n; c++) begin
      exp_q.push_back(2);
      exp_q.push_back(3);
      exp_q.push_back(4);
      exp_q.push_back(5);
    end
    exp_q.push_back(0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (state == 3'd0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_entries(input int s, input int n, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (entries[s] >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
    tests++;
    if ({sv_prec, sv_water, vv_vac, busy, done, fault} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 000000", {sv_prec, sv_water, vv_vac, busy, done, fault});
    end
    tests++;
    if (cycle_cnt !== '0) begin fails++; $display("FAIL reset_cycle_cnt: got %0d want 0", cycle_cnt); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_normal();
    bit ok;
    int e, got, nobs;
    set_cfg(2, 3, 2, 3, 2, 2);
    clear_obs();
    push_run(2);
    repeat (2) begin exp_prec_q.push_back(3); exp_water_q.push_back(3); end
    pulse_start();
    wait_idle(2000, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL normal_timeout: got state %0d want 0", state); end
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL normal_done_at_end: got %b want 1", done); end
    repeat (3) @(negedge clk);
    tests++;
    if (done_clks != 1) begin fails++; $display("FAIL normal_done_width: got %0d want 1", done_clks); end
    tests++;
    if (cycle_cnt !== CW'(2)) begin fails++; $display("FAIL normal_cycle_cnt: got %0d want 2", cycle_cnt); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL normal_busy: got %b want 0", busy); end
    tests++;
    if (overlap) begin fails++; $display("FAIL normal_overlap: got 1 want 0"); end
    nobs = obs_state_q.size();
    tests++;
    if (nobs != exp_q.size()) begin fails++; $display("FAIL normal_nstates: got %0d want %0d", nobs, exp_q.size()); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e   = exp_q.pop_front();
      got = (i < nobs) ? obs_state_q[i] : -1;
      tests++;
      if (got != e) begin fails++; $display("FAIL normal_state[%0d]: got %0d want %0d", i, got, e); end
    end
    for (int i = 0; exp_prec_q.size() > 0; i++) begin
      e   = exp_prec_q.pop_front();
      got = (i < prec_tick_q.size()) ? prec_tick_q[i] : -1;
      tests++;
      if (got != e) begin fails++; $display("FAIL normal_prec_ticks[%0d]: got %0d want %0d", i, got, e); end
    end
    for (int i = 0; exp_water_q.size() > 0; i++) begin
      e   = exp_water_q.pop_front();
      got = (i < water_tick_q.size()) ? water_tick_q[i] : -1;
      tests++;
      if (got != e) begin fails++; $display("FAIL normal_water_ticks[%0d]: got %0d want %0d", i, got, e); end
    end
  endtask

  task automatic test_stop();
    bit ok;
    set_cfg(2, 3, 2, 3, 2, 3);
    clear_obs();
    pulse_start();
    wait_entries(2, 2, 2000, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL stop_reach_ppulse2: got %0d entries want 2", entries[2]); end
    stop = 1'b1;
    @(negedge clk);
    tests++;
    if ({state, sv_prec, vv_vac} !== {3'd6, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL stop_abort: got state=%0d prec=%b vac=%b want state=6 prec=0 vac=1", state, sv_prec, vv_vac);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (state !== 3'd6) begin fails++; $display("FAIL stop_hold: got %0d want 6", state); end
    stop = 1'b0;
    @(negedge clk);
    tests++;
    if (state !== 3'd0) begin fails++; $display("FAIL stop_release: got %0d want 0", state); end
    tests++;
    if (cycle_cnt !== CW'(1)) begin fails++; $display("FAIL stop_cycle_cnt: got %0d want 1", cycle_cnt); end
    tests++;
    if (done_clks != 0 || vv_vac !== 1'b0) begin
      fails++;
      $display("FAIL stop_no_done: got done_clks=%0d vac=%b want 0 0", done_clks, vv_vac);
    end
  endtask

  task automatic test_interlock();
    bit ok;
    set_cfg(2, 3, 2, 3, 2, 2);
    clear_obs();
    pulse_start();
    wait_entries(4, 1, 2000, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL ilk_reach_wpulse: got %0d entries want 1", entries[4]); end
    interlock_ok = 1'b0;
    @(negedge clk);
    tests++;
    if ({state, fault, sv_prec, sv_water, vv_vac, busy} !== {3'd7, 5'b10000}) begin
      fails++;
      $display("FAIL ilk_fault: got state=%0d f=%b p=%b w=%b v=%b b=%b want 7 1 0 0 0 0",
               state, fault, sv_prec, sv_water, vv_vac, busy);
    end
    fault_clr = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (state !== 3'd7) begin fails++; $display("FAIL ilk_clr_needs_ok: got %0d want 7", state); end
    fault_clr    = 1'b0;
    interlock_ok = 1'b1;
    pulse_start();
    repeat (3) @(negedge clk);
    tests++;
    if (state !== 3'd7 || fault !== 1'b1) begin
      fails++;
      $display("FAIL ilk_start_ignored: got state=%0d fault=%b want 7 1", state, fault);
    end
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    tests++;
    if (state !== 3'd0 || fault !== 1'b0) begin
      fails++;
      $display("FAIL ilk_clear: got state=%0d fault=%b want 0 0", state, fault);
    end
  endtask

  task automatic test_zero();
    bit ok;
    int e, got, nobs, d;
    set_cfg(0, 0, 0, 0, 0, 1);
    clear_obs();
    push_run(1);
    pulse_start();
    wait_idle(200, ok);
    tests++;
    if (!ok || done !== 1'b1) begin
      fails++;
      $display("FAIL zero_done: got ok=%b done=%b want 1 1", ok, done);
    end
    @(negedge clk);
    nobs = obs_state_q.size();
    tests++;
    if (nobs != exp_q.size()) begin fails++; $display("FAIL zero_nstates: got %0d want %0d", nobs, exp_q.size()); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e   = exp_q.pop_front();
      got = (i < nobs) ? obs_state_q[i] : -1;
      d   = (i < nobs) ? obs_dwell_q[i] : -1;
      tests++;
      if (got != e) begin fails++; $display("FAIL zero_state[%0d]: got %0d want %0d", i, got, e); end
      if (i > 0) begin
        tests++;
        if (d != 1) begin fails++; $display("FAIL zero_dwell[%0d]: got %0d want 1", i, d); end
      end
    end
    tests++;
    if (prec_clk_q.size() != 1 || water_clk_q.size() != 1) begin
      fails++;
      $display("FAIL zero_npulses: got %0d %0d want 1 1", prec_clk_q.size(), water_clk_q.size());
    end else begin
      tests++;
      if (prec_clk_q[0] != 1 || water_clk_q[0] != 1) begin
        fails++;
        $display("FAIL zero_pulse_width: got %0d %0d want 1 1", prec_clk_q[0], water_clk_q[0]);
      end
    end
    tests++;
    if (done_clks != 1) begin fails++; $display("FAIL zero_done_width: got %0d want 1", done_clks); end
  endtask

  task automatic test_start_edge();
    bit ok;
    set_cfg(1, 1, 1, 1, 1, 1);
    clear_obs();
    start = 1'b1;
    @(negedge clk);
    wait_idle(500, ok);
    repeat (30) @(negedge clk);
    tests++;
    if (!ok || state !== 3'd0 || entries[1] != 1) begin
      fails++;
      $display("FAIL start_held_one_run: got ok=%b state=%0d runs=%0d want 1 0 1", ok, state, entries[1]);
    end
    tests++;
    if (obs_state_q.size() != 6) begin fails++; $display("FAIL start_held_nstates: got %0d want 6", obs_state_q.size()); end
    start = 1'b0;
    set_cfg(1, 1, 1, 1, 1, 0);
    clear_obs();
    pulse_start();
    repeat (20) @(negedge clk);
    tests++;
    if (state !== 3'd0 || obs_state_q.size() != 0 || valve_clks != 0) begin
      fails++;
      $display("FAIL start_n0: got state=%0d changes=%0d valve_clks=%0d want 0 0 0",
               state, obs_state_q.size(), valve_clks);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int e, got, nobs;
    set_cfg(2, 3, 2, 3, 2, 2);
    clear_obs();
    pulse_start();
    wait_entries(3, 2, 2000, ok);
    tests++;
    if (!ok || cycle_cnt !== CW'(1)) begin
      fails++;
      $display("FAIL rstmid_reach: got ok=%b cycle_cnt=%0d want 1 1", ok, cycle_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({state, cycle_cnt, sv_prec, sv_water, vv_vac, busy, done, fault} !== {3'd0, CW'(0), 6'b0}) begin
      fails++;
      $display("FAIL rstmid_clear: got state=%0d cnt=%0d outs=%b want 0 0 000000",
               state, cycle_cnt, {sv_prec, sv_water, vv_vac, busy, done, fault});
    end
    rst = 1'b1;
    @(negedge clk);
    set_cfg(1, 2, 1, 2, 1, 1);
    clear_obs();
    push_run(1);
    pulse_start();
    wait_idle(1000, ok);
    tests++;
    if (!ok || done !== 1'b1) begin fails++; $display("FAIL rstmid_rerun_done: got ok=%b done=%b want 1 1", ok, done); end
    @(negedge clk);
    nobs = obs_state_q.size();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e   = exp_q.pop_front();
      got = (i < nobs) ? obs_state_q[i] : -1;
      tests++;
      if (got != e) begin fails++; $display("FAIL rstmid_state[%0d]: got %0d want %0d", i, got, e); end
    end
    tests++;
    if (cycle_cnt !== CW'(1)) begin fails++; $display("FAIL rstmid_cycle_cnt: got %0d want 1", cycle_cnt); end
  endtask

  initial begin
    rst          = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    interlock_ok = 1'b1;
    fault_clr    = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_normal();
    test_stop();
    test_interlock();
    test_zero();
    test_start_edge();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
